// File: rtl/mod_counter_chain.sv
// Cascadable modulo-N counter chain with DIGITS stages, each WIDTH bits wide.
// Define MOD_COUNTER_CHAIN_UPDOWN_EN to honour dn; otherwise the block only counts up.
module mod_counter_chain #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10,
  parameter int DIGITS  = 2
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    ld_n,
  input  logic                    ent,
  input  logic                    enp,
  input  logic                    dn,
  input  logic [DIGITS*WIDTH-1:0] d,
  output logic [DIGITS*WIDTH-1:0] q,
  output logic                    rco
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("mod_counter_chain: MODULUS must lie in 2..2**WIDTH");
    end
    if (DIGITS < 1) begin : g_bad_digits
      $error("mod_counter_chain: DIGITS must be at least 1");
    end
  endgenerate

  logic [DIGITS*WIDTH-1:0] q_r;
  logic [DIGITS*WIDTH-1:0] q_nxt_s;
  logic                    term_all_s;

`ifdef MOD_COUNTER_CHAIN_UPDOWN_EN
  // Out-of-range digits snap to the first in-range value of the current direction.
  function automatic logic [WIDTH-1:0] step_digit(input logic [WIDTH-1:0] v, input logic down);
    logic [WIDTH-1:0] r;
    if (down) begin
      r = (v == ZERO_V || v > MAX_V) ? MAX_V : v - ONE_V;
    end else begin
      r = (v >= MAX_V) ? ZERO_V : v + ONE_V;
    end
    return r;
  endfunction

  function automatic logic is_term(input logic [WIDTH-1:0] v, input logic down);
    return down ? (v == ZERO_V) : (v == MAX_V);
  endfunction
`else
  logic unused_dn_s;
  assign unused_dn_s = dn;

  function automatic logic [WIDTH-1:0] step_digit(input logic [WIDTH-1:0] v);
    return (v >= MAX_V) ? ZERO_V : v + ONE_V;
  endfunction

  function automatic logic is_term(input logic [WIDTH-1:0] v);
    return v == MAX_V;
  endfunction
`endif

  // Combinational carry chain: each digit advances when all lower digits are terminal.
  always_comb begin
    logic             carry_v;
    logic             term_v;
    logic             dig_term_v;
    logic [WIDTH-1:0] dig_v;
    q_nxt_s    = q_r;
    carry_v    = ent & enp;
    term_v     = 1'b1;
    dig_term_v = 1'b0;
    dig_v      = ZERO_V;
    for (int i = 0; i < DIGITS; i++) begin
      dig_v = q_r[i*WIDTH +: WIDTH];
`ifdef MOD_COUNTER_CHAIN_UPDOWN_EN
      dig_term_v = is_term(dig_v, dn);
      if (carry_v) begin
        q_nxt_s[i*WIDTH +: WIDTH] = step_digit(dig_v, dn);
      end else begin
        q_nxt_s[i*WIDTH +: WIDTH] = dig_v;
      end
`else
      dig_term_v = is_term(dig_v);
      if (carry_v) begin
        q_nxt_s[i*WIDTH +: WIDTH] = step_digit(dig_v);
      end else begin
        q_nxt_s[i*WIDTH +: WIDTH] = dig_v;
      end
`endif
      carry_v = carry_v & dig_term_v;
      term_v  = term_v & dig_term_v;
    end
    term_all_s = term_v;
  end

  // Count state: clear beats load, load beats count.
  always_ff @(posedge clk) begin
    if (clr) begin
      q_r <= {(DIGITS*WIDTH){1'b0}};
    end else if (!ld_n) begin
      q_r <= d;
    end else begin
      q_r <= q_nxt_s;
    end
  end

  assign q   = q_r;
  assign rco = ent & term_all_s;

endmodule

// File: doc/mod_counter_chain.md
# mod_counter_chain

Parametrised synchronous modulo-N counter chain: DIGITS cascaded digit stages, each WIDTH bits wide and counting modulo MODULUS, with parallel load, count enables and ripple-carry output. It generalises the single-stage 74162-style decade counter with multi-digit width, arbitrary modulus and up/down counting. Chains of this block cascade through ENT/RCO exactly as discrete counters do.

## Interface
- WIDTH, 4, bits per digit
- MODULUS, 10, count modulus per digit; legal range 2..2^WIDTH, elaboration error otherwise
- DIGITS, 2, number of cascaded digits, ≥1
- CLK  in  1  clock; all state changes on rising edge
- CLR  in  1  reset, synchronous, active-high
- \~LD  in  1  parallel load, active-low, synchronous
- ENT  in  1  count enable, also gates RCO
- ENP  in  1  count enable, does not affect RCO
- DN  in  1  count direction: 0 up, 1 down
- D  in  DIGITS*WIDTH  load data; digit i at D[i*WIDTH +: WIDTH]
- Q  out  DIGITS*WIDTH  count value, same digit packing as D
- RCO  out  1  ripple carry/borrow out, active-high

## Operation
- One clock (CLK); reset is synchronous and active-high (CLR).
- Per-edge priority: CLR > load (\~LD=0) > count (ENT=1 & ENP=1) > hold.
- CLR: all digits to 0. Reset value: Q=0; RCO=0 unless ENT=1 and DN=1 (all-zero is the down-terminal state).
- Load: Q<=D verbatim, including out-of-range digit values (≥MODULUS). Ignores ENT/ENP.
- Count up, digit i: advances when counting is enabled and every digit j<i equals MODULUS-1. Value MODULUS-1 wraps to 0.
- Count down, digit i: advances when counting is enabled and every digit j<i equals 0. Value 0 wraps to MODULUS-1.
- Out-of-range digit (≥MODULUS): when it is due to advance, it goes to 0 (up) or MODULUS-1 (down). It is never terminal, so it produces no carry or borrow into higher digits.
- Terminal state: up = all digits MODULUS-1; down = all digits 0.
- RCO = ENT & terminal(DN). Purely combinational from Q, ENT and DN, so it follows those inputs within the same cycle.
- Digit arithmetic is WIDTH bits, with no overflow into neighbouring digit fields. When MODULUS=2^WIDTH, the block behaves as a plain binary counter of DIGITS*WIDTH bits.
- DN may change on any cycle; the next edge uses the new direction. There is no pipeline state.

## Timing
- Load, clear and count all take effect at the rising edge where they are sampled; Q is valid one cycle later. Latency is 1.
- All digits update on the same edge. The internal carry chain is combinational and does not ripple across clock cycles.
- RCO has zero-cycle latency from ENT/DN and one cycle from the edge that updates Q.
- Cascading: block k's RCO drives block k+1's ENT, with ENP shared and CLK common. The full chain advances on one edge.
- CLR and \~LD in the same cycle: the clear wins. CLR in the middle of a count sequence gives Q=0 on the next edge, regardless of enables.

## Configuration
- MOD_COUNTER_CHAIN_UPDOWN_EN defined: DN is honoured as specified above.
- Macro not defined: the block is an up-only counter. DN is ignored (treated as 0), all down-count logic is removed, and RCO = ENT & (all digits MODULUS-1). The port list is unchanged.

## Test plan
- DIGITS=2, MODULUS=10. CLR=1 for 1 cycle, then ENT=ENP=1, DN=0 for 100 cycles → Q steps 0x00..0x99 in BCD, then wraps to 0x00. RCO=1 exactly while Q=0x99.
- \~LD=0 with D=0x47 for one edge, then count up → Q=0x47, then 0x48, 0x49, 0x50.
- DN=1 from Q=0x01 → 0x00 (RCO=1 while 0x00 with ENT=1), then 0x99. Build with the macro undefined: the same stimulus counts up 0x01→0x02 and RCO stays 0.
- Q=0x99, ENP=0, ENT=1 → Q holds and RCO=1. Drop ENT to 0 → RCO=0 in the same cycle and Q still holds.
- CLR=1 and \~LD=0 with D=0x55 on the same edge → Q=0x00. Then CLR=1 during counting at Q=0x37 → next Q=0x00.
- Load D=0x0F, then count up → Q=0x00 (low digit 15→0, no carry into upper digit). Load D=0x9F with DN=0 → Q=0x90.
